// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with a 2-entry {pc, instr} buffer in front of decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        x_redirect_i,
  input  logic [31:0] pc_calc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        d_ready_i,
  output logic        f_valid_o,
  output logic [31:0] f_instr_o,
  output logic [31:0] f_pc_o
);
  typedef enum logic [1:0] {IDLE, REQ, KILL} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, kaddr_q, kaddr_d;
  logic [1:0]  occ_q, occ_d, widx;
  logic [63:0] e0_q, e0_d, e1_q, e1_d;
  logic        push, pop;
  assign imem_req_o  = state_q != IDLE;
  // a killed request keeps presenting its original address until the memory acks it
  assign imem_addr_o = (state_q == KILL) ? kaddr_q : pc_q;
  assign f_valid_o   = occ_q != 2'd0;
  assign f_pc_o      = e0_q[63:32];
  assign f_instr_o   = e0_q[31:0];
  always_comb begin
    push    = (state_q == REQ) & imem_ack_i & ~x_redirect_i;
    pop     = f_valid_o & d_ready_i & ~x_redirect_i;
    widx    = occ_q - {1'b0, pop};
    occ_d   = x_redirect_i ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
    pc_d    = x_redirect_i ? (pc_calc_i & 32'hFFFF_FFFC) : push ? pc_q + 32'd4 : pc_q;
    kaddr_d = (state_q == REQ) ? pc_q : kaddr_q;
    e0_d    = (push && widx == 2'd0) ? {pc_q, imem_rdata_i} : (pop && occ_q == 2'd2) ? e1_q : e0_q;
    e1_d    = (push && widx == 2'd1) ? {pc_q, imem_rdata_i} : e1_q;
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = (occ_d < 2'd2) ? REQ : IDLE;
      REQ:     state_d = x_redirect_i ? (imem_ack_i ? REQ : KILL)
                       : (imem_ack_i && occ_d == 2'd2) ? IDLE : REQ;
      KILL:    state_d = imem_ack_i ? REQ : KILL;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC & 32'hFFFF_FFFC;
      kaddr_q <= RESET_PC & 32'hFFFF_FFFC;
      occ_q   <= 2'd0;
      e0_q    <= {RESET_PC, 32'h0000_0013};
      e1_q    <= {RESET_PC, 32'h0000_0013};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kaddr_q <= kaddr_d;
      occ_q   <= occ_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized scoreboard bench; the model is the in-order instruction stream restarted at each redirect.
module tb_if_fetch;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 0, rstn = 0, redir = 0, ack = 0, rdy = 0;
  logic [31:0] tgt = 0, rdata = 0;
  logic imem_req_o, f_valid_o;
  logic [31:0] imem_addr_o, f_instr_o, f_pc_o;
  int total = 0, bad = 0, consumed = 0, c0 = 0;
  bit mon_on = 0, wrand = 0, armed = 0, kill = 0;
  int wmax = 0, wcnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mpc = RPC;
  logic p_rstn = 0, p_req = 0, p_ack = 0, p_redir = 0, p_push = 0;
  logic [31:0] p_addr = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rstn_i(rstn), .x_redirect_i(redir), .pc_calc_i(tgt),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(ack),
    .imem_rdata_i(rdata), .d_ready_i(rdy), .f_valid_o(f_valid_o),
    .f_instr_o(f_instr_o), .f_pc_o(f_pc_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] w);
    total++;
    if (a !== w) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, w);
    end
  endtask

  task automatic step(input bit r, input bit rd, input bit rx, input logic [31:0] t);
    @(posedge clk); #1;
    rstn = r; rdy = rd; redir = rx; tgt = t; ack = 0;
    if (!r || imem_req_o !== 1'b1) armed = 0;
    else begin
      if (!armed) begin
        armed = 1;
        wcnt = wrand ? $urandom_range(0, 3) : wmax;
      end
      if (wcnt == 0) begin ack = 1; armed = 0; end
      else wcnt--;
    end
    rdata = ack ? mem_word(imem_addr_o) : $urandom();
    if (!r) begin exp_q.delete(); mpc = RPC; end
    else if (rx) begin exp_q.delete(); mpc = t & 32'hFFFF_FFFC; end
    while (exp_q.size() < 4) begin
      exp_q.push_back({mpc, mem_word(mpc)});
      mpc += 32'd4;
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    logic [63:0] e;
    if (!p_rstn) begin
      chk("reset_req", {31'd0, imem_req_o}, 0);
      chk("reset_valid", {31'd0, f_valid_o}, 0);
    end else begin
      if (p_redir) chk("flush_valid", {31'd0, f_valid_o}, 0);
      if (p_req && !p_ack) begin
        chk("hold_req", {31'd0, imem_req_o}, 1);
        chk("hold_addr", imem_addr_o, p_addr);
      end
      if (p_push) chk("ack_latency", {31'd0, f_valid_o}, 1);
    end
    if (imem_req_o) chk("addr_align", {30'd0, imem_addr_o[1:0]}, 0);
    if (rstn && f_valid_o && rdy && !redir) begin
      consumed++;
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_pc", f_pc_o, e[63:32]);
        chk("sb_instr", f_instr_o, e[31:0]);
      end
    end
    p_push = rstn && imem_req_o && ack && !redir && !kill;
    if (!rstn) kill = 0;
    else if (imem_req_o && ack) kill = 0;
    else if (imem_req_o && redir) kill = 1;
    p_rstn = rstn; p_req = imem_req_o; p_ack = ack; p_redir = redir; p_addr = imem_addr_o;
  end

  initial begin
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    mon_on = 1;
    step(0, 1, 0, 0);
    chk("rst_req", {31'd0, imem_req_o}, 0);
    chk("rst_valid", {31'd0, f_valid_o}, 0);
    chk("rst_instr", f_instr_o, 32'h0000_0013);
    chk("rst_pc", f_pc_o, RPC);
    step(1, 1, 0, 0);
    chk("first_idle", {31'd0, imem_req_o}, 0);
    step(1, 1, 0, 0);
    chk("first_req", {31'd0, imem_req_o}, 1);
    chk("first_addr", imem_addr_o, RPC);
    for (int i = 1; i < 3; i++) begin
      step(1, 1, 0, 0);
      chk("stream_addr", imem_addr_o, RPC + 32'(4 * i));
      chk("stream_valid", {31'd0, f_valid_o}, 1);
      chk("stream_pc", f_pc_o, RPC + 32'(4 * (i - 1)));
    end
    repeat (5) step(1, 0, 0, 0);
    chk("stall_req", {31'd0, imem_req_o}, 0);
    chk("stall_valid", {31'd0, f_valid_o}, 1);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("resume_addr", imem_addr_o, 32'h10);
    chk("resume_pc", f_pc_o, 32'hC);
    repeat (3) step(1, 0, 0, 0);
    wmax = 3;
    step(1, 0, 1, 32'h10);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) wmax = 0;
      step(1, 1, i == 1, 32'h100);
      chk("kill_req", {31'd0, imem_req_o}, 1);
      chk("kill_addr", imem_addr_o, 32'h10);
    end
    step(1, 1, 0, 0);
    chk("kill_valid", {31'd0, f_valid_o}, 0);
    chk("kill_next", imem_addr_o, 32'h100);
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h203);
    step(1, 1, 0, 0);
    chk("redir_ack_addr", imem_addr_o, 32'h200);
    chk("redir_ack_valid", {31'd0, f_valid_o}, 0);
    step(1, 1, 1, 32'hFFFF_FFFE);
    step(1, 1, 0, 0);
    chk("wrap_top", imem_addr_o, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap_zero", imem_addr_o, 32'h0);
    chk("wrap_pc", f_pc_o, 32'hFFFF_FFFC);
    wmax = 3;
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h40);
    step(0, 1, 0, 0);
    chk("kill_rst_req", {31'd0, imem_req_o}, 1);
    chk("kill_rst_addr", imem_addr_o, 32'h4);
    step(0, 1, 0, 0);
    chk("rst_kill_req", {31'd0, imem_req_o}, 0);
    chk("rst_kill_valid", {31'd0, f_valid_o}, 0);
    step(1, 1, 0, 0);
    chk("rel_idle", {31'd0, imem_req_o}, 0);
    step(1, 1, 0, 0);
    chk("rel_addr", imem_addr_o, RPC);
    wrand = 1;
    c0 = consumed;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom());
    repeat (10) step(1, 1, 0, 0);
    chk("progress", {31'd0, (consumed - c0) > 400}, 1);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
